vfpu_job_ctrl: RTL and testbench
================================

# vfpu_job_ctrl

Job controller for the vector FPU hardware processing engine. It sits between the memory-mapped control register file and the datapath. On a start trigger it snapshots the job registers and hands the configuration to the operand-A, operand-B and result streamers with a valid/ready handshake. It then enables the FPU engine, counts result beats against the programmed transaction size, and raises a completion event once all streamers report done.

## Interface
- NB_REGS, 14, number of job registers (indices 0..13)
- REG_W, 32, register width
- OP_W, 4, operation-select width (LSBs of register 13)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft clear
- start_i  in  1  one-cycle trigger from the register file
- reg_file_i  in  NB_REGS*REG_W  flattened register file; register n occupies bits [n*REG_W +: REG_W]
- stream_cfg_o  out  12*REG_W  shadow copy of registers 0..11 (A: 0-3, B: 4-7, result: 8-11)
- stream_cfg_valid_o  out  3  configuration valid; bit 0 = A, bit 1 = B, bit 2 = result
- stream_cfg_ready_i  in  3  streamer accepts configuration
- stream_done_i  in  3  one-cycle completion pulse per streamer
- op_sel_o  out  OP_W  latched operation select
- engine_en_o  out  1  FPU engine enable
- result_valid_i, result_ready_i  in  1 each  engine output handshake (observed, not driven)
- tx_count_o  out  REG_W  result beats counted so far
- busy_o  out  1  job in progress
- done_o  out  1  one-cycle completion event

## Operation
- States: IDLE, LATCH, ISSUE, RUN, DONE.
- IDLE:
  - start_i=1 moves to LATCH.
  - The same edge copies registers 0..13 into the shadow (stream_cfg_o, op_sel_o, internal tx_size), clears tx_count_o and clears the sticky done flags.
- LATCH (one cycle):
  - tx_size==0 moves to DONE; streamers and engine are never started.
  - Otherwise moves to ISSUE.
- ISSUE:
  - All three stream_cfg_valid_o bits rise together on entry.
  - Each bit drops individually on the cycle after its valid&ready handshake.
  - Once all three are accepted, moves to RUN.
- stream_done_i pulses are captured into sticky flags during ISSUE and RUN, and ignored in other states.
- RUN:
  - engine_en_o=1.
  - Each result_valid_i&result_ready_i increments tx_count_o.
  - The count saturates at tx_size; extra beats are not counted.
  - Moves to DONE when tx_count_o==tx_size and all three sticky done flags are set. Both conditions may complete on the same cycle.
- DONE (one cycle): done_o=1, then IDLE.
- busy_o=1 in every state except IDLE.
- start_i outside IDLE is ignored. Register-file changes outside IDLE do not affect the shadow.
- clear_i has priority over everything:
  - Next state is IDLE.
  - All outputs return to reset values, except that the shadow registers hold.
  - No done_o pulse is emitted.

## Timing
- Reset values:
  - All outputs 0, including stream_cfg_o, op_sel_o and tx_count_o.
  - State IDLE; sticky flags cleared.
- start_i sampled high at edge k: LATCH during cycle k+1; stream_cfg_valid_o high from cycle k+2.
- An already-high ready completes the handshake in that first valid cycle; RUN is then entered at k+3.
- stream_cfg_valid_o, once raised, stays high until its handshake; it never drops early except on clear_i.
- tx_count_o updates the cycle after the beat.
- done_o is asserted the cycle after the terminal condition is met; busy_o falls one cycle after done_o.
- A stream_done_i pulse on the same edge as the final result beat still counts toward that edge's terminal check.
- An rst_ni assertion mid-job aborts immediately and asynchronously to the reset state.

## Configuration
- Macro: VFPU_JOB_CTRL_PERF_CNT_EN.
- When defined:
  - Adds output perf_cycles_o (REG_W).
  - The counter clears on the LATCH entry edge and increments every cycle while busy_o=1, saturating at all ones.
  - It holds its value in IDLE and clears on clear_i.
- When undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- tx_size=8, all readies high, 8 result beats, then streamer dones in order A, B, result -> valids high exactly one cycle (k+2), done_o once, tx_count_o=8, busy_o low afterwards.
- Staggered readies (A at +0, B at +3, result at +5 cycles) -> each valid drops individually after its handshake; engine_en_o rises only after the result handshake.
- tx_size=0 -> no valid, no engine_en_o, done_o at k+2.
- 10 beats with tx_size=6 -> tx_count_o stops at 6; done_o only once all three stream_done_i are seen.
- clear_i during RUN -> IDLE next cycle, no done_o; a new start_i then runs a full job normally.
- Second start_i during RUN with modified reg_file_i -> ignored; stream_cfg_o unchanged; with the macro defined, perf_cycles_o equals the job length in cycles.

Source files
------------

// File: rtl/vfpu_job_ctrl.sv
// Vector FPU job controller: snapshots job registers, issues streamer configs, runs engine, signals completion.
// Latency: start -> config valid in 2 cycles; terminal condition -> done_o 1 cycle later.
// Backpressure: config held valid per streamer until accepted; VFPU_JOB_CTRL_PERF_CNT_EN adds a busy-cycle counter.
module vfpu_job_ctrl #(
    parameter int NB_REGS = 14,
    parameter int REG_W   = 32,
    parameter int OP_W    = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [NB_REGS*REG_W-1:0] reg_file_i,
    output logic [12*REG_W-1:0]  stream_cfg_o,
    output logic [2:0]           stream_cfg_valid_o,
    input  logic [2:0]           stream_cfg_ready_i,
    input  logic [2:0]           stream_done_i,
    output logic [OP_W-1:0]      op_sel_o,
    output logic                 engine_en_o,
    input  logic                 result_valid_i,
    input  logic                 result_ready_i,
    output logic [REG_W-1:0]     tx_count_o,
    output logic                 busy_o,
`ifdef VFPU_JOB_CTRL_PERF_CNT_EN
    output logic [REG_W-1:0]     perf_cycles_o,
`endif
    output logic                 done_o
);

    typedef enum logic [2:0] {IDLE, LATCH, ISSUE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [12*REG_W-1:0]   cfg_q;
    logic [OP_W-1:0]       op_q;
    logic [REG_W-1:0]      size_q;
    logic [REG_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            vld_q, vld_rem;
    logic [2:0]            sticky_q, sticky_d;
    logic                  beat;
    logic                  load;

    // Register 13 carries only the op select; its upper bits are don't-care.
    logic unused_reg_bits;
    assign unused_reg_bits = ^reg_file_i[NB_REGS*REG_W-1:13*REG_W+OP_W];

    assign beat    = result_valid_i & result_ready_i;
    assign load    = (state_q == IDLE) & start_i;
    assign vld_rem = vld_q & ~stream_cfg_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == RUN) && beat && (cnt_q < size_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        sticky_d = sticky_q;
        if ((state_q == ISSUE) || (state_q == RUN)) begin
            sticky_d = sticky_q | stream_done_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = LATCH;
            LATCH:   state_d = (size_q == '0) ? DONE : ISSUE;
            ISSUE:   if (vld_rem == 3'b000) state_d = RUN;
            RUN:     if ((cnt_d == size_q) && (&sticky_d)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            vld_q    <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else if (clear_i) begin
            state_q  <= IDLE;
            vld_q    <= '0;
            sticky_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                sticky_q <= '0;
                cnt_q    <= '0;
            end else begin
                sticky_q <= sticky_d;
                cnt_q    <= cnt_d;
            end
            // All three configs go out together; each retires on its own handshake.
            if ((state_q == LATCH) && (state_d == ISSUE)) begin
                vld_q <= 3'b111;
            end else begin
                vld_q <= vld_rem;
            end
        end
    end

    // Shadow survives clear so software can inspect the aborted job.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q  <= '0;
            op_q   <= '0;
            size_q <= '0;
        end else if (!clear_i && load) begin
            cfg_q  <= reg_file_i[12*REG_W-1:0];
            size_q <= reg_file_i[12*REG_W +: REG_W];
            op_q   <= reg_file_i[13*REG_W +: OP_W];
        end
    end

`ifdef VFPU_JOB_CTRL_PERF_CNT_EN
    logic [REG_W-1:0] perf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (clear_i || load) begin
            perf_q <= '0;
        end else if ((state_q != IDLE) && (perf_q != '1)) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_cycles_o = perf_q;
`endif

    assign stream_cfg_o       = cfg_q;
    assign stream_cfg_valid_o = vld_q;
    assign op_sel_o           = op_q;
    assign engine_en_o        = (state_q == RUN);
    assign tx_count_o         = cnt_q;
    assign busy_o             = (state_q != IDLE);
    assign done_o             = (state_q == DONE);

endmodule

// File: tb/tb_vfpu_job_ctrl.sv
// Bench for vfpu_job_ctrl: directed job scenarios plus randomized traffic against a job-level model.
module tb_vfpu_job_ctrl;
    localparam int NB = 14;
    localparam int W  = 32;
    localparam int OPW = 4;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b1;
    logic             clear = 1'b0;
    logic             start = 1'b0;
    logic [NB*W-1:0]  reg_file = '0;
    logic [12*W-1:0]  cfg;
    logic [2:0]       cfg_vld;
    logic [2:0]       cfg_rdy = 3'b000;
    logic [2:0]       sdone = 3'b000;
    logic [OPW-1:0]   op;
    logic             eng;
    logic             rv = 1'b0;
    logic             rr = 1'b0;
    logic [W-1:0]     txc;
    logic             busy;
    logic             done;
`ifdef VFPU_JOB_CTRL_PERF_CNT_EN
    logic [W-1:0]     perf;
`endif

    always #5 clk = ~clk;

    vfpu_job_ctrl #(.NB_REGS(NB), .REG_W(W), .OP_W(OPW)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .clear_i            (clear),
        .start_i            (start),
        .reg_file_i         (reg_file),
        .stream_cfg_o       (cfg),
        .stream_cfg_valid_o (cfg_vld),
        .stream_cfg_ready_i (cfg_rdy),
        .stream_done_i      (sdone),
        .op_sel_o           (op),
        .engine_en_o        (eng),
        .result_valid_i     (rv),
        .result_ready_i     (rr),
        .tx_count_o         (txc),
        .busy_o             (busy),
`ifdef VFPU_JOB_CTRL_PERF_CNT_EN
        .perf_cycles_o      (perf),
`endif
        .done_o             (done)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [383:0] act, input logic [383:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    // Job-level model: tracks what the job has achieved so far rather than a state register.
    typedef struct packed {
        logic         job;    // a job occupies the controller
        logic [1:0]   age;    // 1 = snapshot cycle, 2 = past it
        logic [2:0]   pend;   // configs offered but not yet taken
        logic         run;    // engine working
        logic         devt;   // completion event showing
        logic [31:0]  cnt;
        logic [31:0]  size;
        logic [2:0]   dmask;
        logic [383:0] cfg;
        logic [3:0]   op;
        logic [31:0]  perf;
    } mdl_t;

    mdl_t m = '0;

    function automatic mdl_t step(input mdl_t c);
        mdl_t n = c;
        if (clear) begin
            n.job = 0; n.age = 0; n.pend = 0; n.run = 0; n.devt = 0;
            n.cnt = 0; n.dmask = 0; n.perf = 0;
            return n;
        end
        if (!c.job && start) n.perf = 0;
        else if (c.job && c.perf != 32'hFFFF_FFFF) n.perf = c.perf + 1;
        if (c.devt) begin
            n.devt = 0; n.job = 0;
        end else if (!c.job) begin
            if (start) begin
                n.job = 1; n.age = 1; n.cnt = 0; n.dmask = 0;
                n.cfg = reg_file[383:0];
                n.size = reg_file[12*W +: W];
                n.op = reg_file[13*W +: OPW];
            end
        end else if (c.age == 1) begin
            n.age = 2;
            if (c.size == 0) n.devt = 1;
            else n.pend = 3'b111;
        end else if (c.pend != 0) begin
            n.dmask = c.dmask | sdone;
            n.pend = c.pend & ~cfg_rdy;
            n.run = (n.pend == 0);
        end else if (c.run) begin
            if (rv && rr && c.cnt < c.size) n.cnt = c.cnt + 1;
            n.dmask = c.dmask | sdone;
            if (n.cnt == c.size && n.dmask == 3'b111) begin
                n.run = 0; n.devt = 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) m <= '0;
        else m <= step(m);
    end

    always @(negedge clk) begin
        check("busy", busy, m.job);
        check("done", done, m.devt);
        check("engine_en", eng, m.run);
        check("cfg_valid", cfg_vld, m.pend);
        check("tx_count", txc, m.cnt);
        check("op_sel", op, m.op);
        check("stream_cfg", cfg, m.cfg);
`ifdef VFPU_JOB_CTRL_PERF_CNT_EN
        check("perf_cycles", perf, m.perf);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_regs(input int size);
        for (int i = 0; i < NB; i++) reg_file[i*W +: W] = $urandom;
        reg_file[12*W +: W] = size;
    endtask

    task automatic wait_run();
        int t = 0;
        while (!eng && t < 50) begin tick(); t++; end
        check("wait_run_bound", eng, 1'b1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin tick(); t++; end
        check("wait_done_bound", done, 1'b1);
    endtask

    task automatic run_job(input int size, input int beats);
        set_regs(size);
        cfg_rdy = 3'b111;
        start = 1; tick(); start = 0;
        wait_run();
        rv = 1; rr = 1;
        repeat (beats) tick();
        rv = 0; rr = 0;
        sdone = 3'b111; tick(); sdone = 0;
        wait_done();
        tick();
    endtask

    logic [383:0] saved;
    int ks;
    int len;

    initial begin
        #2 rst_ni = 0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_cfg", cfg, '0);
        check("rst_txc", txc, '0);
        check("rst_vld", cfg_vld, 3'b000);
        tick(); tick();
        rst_ni = 1;
        tick();

        // tx_size 8, readies high, dones A,B,result in order
        set_regs(8); cfg_rdy = 3'b111;
        start = 1; tick(); start = 0;
        @(negedge clk);
        check("t1_latch_vld", cfg_vld, 3'b000);
        check("t1_latch_busy", busy, 1'b1);
        tick(); @(negedge clk);
        check("t1_vld_k2", cfg_vld, 3'b111);
        tick(); @(negedge clk);
        check("t1_vld_drop", cfg_vld, 3'b000);
        check("t1_eng", eng, 1'b1);
        rv = 1; rr = 1;
        repeat (8) tick();
        rv = 0; rr = 0;
        @(negedge clk);
        check("t1_cnt", txc, 8);
        check("t1_no_done", done, 1'b0);
        sdone = 3'b001; tick(); sdone = 3'b010; tick(); sdone = 3'b100; tick(); sdone = 0;
        @(negedge clk);
        check("t1_done", done, 1'b1);
        tick(); @(negedge clk);
        check("t1_idle", busy, 1'b0);
        check("t1_done_once", done, 1'b0);

        // staggered readies: A at +0, B at +3, result at +5
        set_regs(4); cfg_rdy = 3'b000;
        start = 1; tick(); start = 0;
        tick();
        for (int i = 0; i < 8; i++) begin
            cfg_rdy = {i >= 5, i >= 3, 1'b1};
            @(negedge clk);
            check("t2_vld", cfg_vld, {i <= 5, i <= 3, i == 0});
            check("t2_eng", eng, i > 5);
            tick();
        end
        rv = 1; rr = 1;
        repeat (3) tick();
        sdone = 3'b111; tick();
        rv = 0; rr = 0; sdone = 0;
        @(negedge clk);
        check("t2_done", done, 1'b1);
        check("t2_cnt", txc, 4);
        tick();

        // tx_size 0
        set_regs(0);
        start = 1; tick(); start = 0;
        tick(); @(negedge clk);
        check("t3_done_k2", done, 1'b1);
        check("t3_vld", cfg_vld, 3'b000);
        check("t3_eng", eng, 1'b0);
        tick(); @(negedge clk);
        check("t3_idle", busy, 1'b0);

        // 10 beats against tx_size 6
        set_regs(6); cfg_rdy = 3'b111;
        start = 1; tick(); start = 0;
        wait_run();
        rv = 1; rr = 1;
        repeat (10) tick();
        rv = 0; rr = 0;
        @(negedge clk);
        check("t4_sat", txc, 6);
        sdone = 3'b011; tick(); sdone = 0;
        tick(); tick();
        @(negedge clk);
        check("t4_wait_done", done, 1'b0);
        check("t4_busy", busy, 1'b1);
        sdone = 3'b100; tick(); sdone = 0;
        @(negedge clk);
        check("t4_done", done, 1'b1);
        tick();

        // clear during RUN, then a normal job
        set_regs(5); cfg_rdy = 3'b111;
        start = 1; tick(); start = 0;
        wait_run();
        rv = 1; rr = 1;
        repeat (2) tick();
        rv = 0; rr = 0;
        saved = cfg;
        clear = 1; tick(); clear = 0;
        @(negedge clk);
        check("t5_busy", busy, 1'b0);
        check("t5_txc", txc, 0);
        check("t5_done", done, 1'b0);
        check("t5_shadow", cfg, saved);
        run_job(5, 5);
        check("t5_rerun_cnt", txc, 5);

        // second start during RUN with new registers is ignored
        set_regs(7); cfg_rdy = 3'b111;
        start = 1; tick(); start = 0;
        ks = cyc;
        wait_run();
        saved = cfg;
        set_regs(3);
        start = 1; tick(); start = 0;
        rv = 1; rr = 1;
        repeat (7) tick();
        rv = 0; rr = 0;
        sdone = 3'b111; tick(); sdone = 0;
        wait_done();
        len = cyc - ks + 1;
        check("t6_shadow", cfg, saved);
        check("t6_cnt", txc, 7);
        tick();
`ifdef VFPU_JOB_CTRL_PERF_CNT_EN
        @(negedge clk);
        check("t6_perf", perf, len);
`endif

        // randomized traffic with occasional clears and async resets
        for (int c = 0; c < 4000; c++) begin
            clear = ($urandom % 64) == 0;
            start = ($urandom % 6) == 0;
            for (int i = 0; i < NB; i++) reg_file[i*W +: W] = $urandom;
            reg_file[12*W +: W] = $urandom % 8;
            cfg_rdy = 3'($urandom);
            sdone = (($urandom % 5) == 0) ? 3'($urandom) : 3'b000;
            rv = 1'($urandom);
            rr = 1'($urandom);
            if (c % 700 == 350) begin
                rst_ni = 0;
                @(negedge clk);
                check("rnd_rst_busy", busy, 1'b0);
                check("rnd_rst_txc", txc, 0);
                tick();
                rst_ni = 1;
            end
            tick();
        end
        clear = 0; start = 0; rv = 0; rr = 0; sdone = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
